// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int DCNT_W   = 4;

  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;

  // Lowest-index active row wins when several rows are low on one column.
  function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] act);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (act[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side and key-event signals of the keypad scanner, grouped as one bundle.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_COLS-1:0] col_out;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_scan_tick_gen.sv
// Free-running scan-rate counter; tick is high for one clk each time it reaches all-ones.
module scan_tick_gen #(
  parameter int SCAN_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [SCAN_DIV-1:0] ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

  logic [SCAN_DIV-1:0] cnt_q;
  logic [SCAN_DIV-1:0] cnt_d;

  assign cnt_d = cnt_q + ONE;
  assign tick  = &cnt_q;

  // Counter wraps naturally from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates an active-low column, synchronises the rows and
// debounces press/release, emitting a key code with a one-cycle valid strobe.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam logic [DCNT_W-1:0] DCNT_ONE  = 4'd1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CNT);
  localparam bit                FAST_ACCEPT = (DEBOUNCE_CNT == 1);

  logic                tick;
  logic [NUM_ROWS-1:0] rs_meta_q;
  logic [NUM_ROWS-1:0] rs_q;
  state_e              state_q;
  logic [1:0]          col_q;
  logic [1:0]          lat_row_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [DCNT_W-1:0]   dcnt_d;
  logic [NUM_COLS-1:0] col_out_q;
  logic [NUM_COLS-1:0] col_out_d;
  logic [1:0]          col_d;
  logic [3:0]          key_code_q;
  logic                key_valid_q;
  logic                key_held_q;

  logic [NUM_ROWS-1:0] row_act;
  logic [1:0]          first_row;
  logic                lat_act;
  logic                any_act;
  logic                count_done;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign row_act    = ~rs_q;
  assign any_act    = |row_act;
  assign first_row  = lowest_row(row_act);
  assign lat_act    = row_act[lat_row_q];
  assign dcnt_d     = dcnt_q + DCNT_ONE;
  assign count_done = (dcnt_d == DCNT_LAST);
  assign col_d      = col_q + 2'd1;
  assign col_out_d  = {col_out_q[NUM_COLS-2:0], col_out_q[NUM_COLS-1]};

  // Two-flop synchroniser for the asynchronous row pins; idle means all high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_meta_q <= 4'hF;
      rs_q      <= 4'hF;
    end else begin
      rs_meta_q <= kp.row_in;
      rs_q      <= rs_meta_q;
    end
  end

  // Scan/debounce FSM with registered outputs; evaluates only on tick cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      col_out_q   <= COL_IDLE;
      lat_row_q   <= 2'd0;
      dcnt_q      <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (any_act) begin
              lat_row_q <= first_row;
              if (FAST_ACCEPT) begin
                key_code_q  <= {first_row, col_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                dcnt_q      <= '0;
                state_q     <= HELD;
              end else begin
                dcnt_q  <= DCNT_ONE;
                state_q <= DEBOUNCE;
              end
            end else begin
              col_q     <= col_d;
              col_out_q <= col_out_d;
            end
          end
          DEBOUNCE: begin
            if (lat_act) begin
              if (count_done) begin
                key_code_q  <= {lat_row_q, col_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                dcnt_q      <= '0;
                state_q     <= HELD;
              end else begin
                dcnt_q <= dcnt_d;
              end
            end else begin
              // Bounce: drop back to SCAN on the same column.
              dcnt_q  <= '0;
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (!lat_act) begin
              if (count_done) begin
                key_held_q <= 1'b0;
                dcnt_q     <= '0;
                col_q      <= col_d;
                col_out_q  <= col_out_d;
                state_q    <= SCAN;
              end else begin
                dcnt_q <= dcnt_d;
              end
            end else begin
              dcnt_q <= '0;
            end
          end
          default: begin
            state_q <= SCAN;
            dcnt_q  <= '0;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign kp.col_out   = col_out_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
